vc_input_buffer: RTL

Input-port buffer of the NoC router. It holds two virtual-channel FIFOs (VC0, VC1) and generates the per-VC valid flags consumed by the VC selection controller. It dequeues one flit per cycle from the VC named by the controller's selected_vc. Freed slots are returned as per-VC credits to the upstream router.

---
 rtl/vc_input_buffer_if.sv | 38 +++
 rtl/vc_input_buffer.sv | 107 ++++++++++
 2 files changed

// File: rtl/vc_input_buffer_if.sv
// ============================================================================
// Module      : vc_input_buffer_if
// Description : Flit input, VC selection and dequeue/credit bundle of a
//               router input port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface vc_input_buffer_if #(
    parameter int FLIT_W = 32
);
    logic              in_valid;
    logic              in_vc;
    logic [FLIT_W-1:0] in_flit;
    logic [1:0]        selected_vc;
    logic              out_ready;
    logic              vc0_valid;
    logic              vc1_valid;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_out_valid;
    logic              flit_out_vc;
    logic [1:0]        credit_out;
    logic              overflow_err;

    modport master (
        output in_valid, in_vc, in_flit, selected_vc, out_ready,
        input  vc0_valid, vc1_valid, flit_out, flit_out_valid,
               flit_out_vc, credit_out, overflow_err
    );

    modport slave (
        input  in_valid, in_vc, in_flit, selected_vc, out_ready,
        output vc0_valid, vc1_valid, flit_out, flit_out_valid,
               flit_out_vc, credit_out, overflow_err
    );
endinterface

`default_nettype wire

// File: rtl/vc_input_buffer.sv
// ============================================================================
// Module      : vc_input_buffer
// Description : Two-VC input buffer with registered dequeue and per-VC credits.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vc_input_buffer #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    vc_input_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              w_rd_ok;
    logic              w_rd_vc;
    logic [1:0]        w_rd_en;
    logic [1:0]        w_wr_req;
    logic [1:0]        w_wr_en;
    logic [1:0]        w_nonempty;
    logic [FLIT_W-1:0] w_head [2];

    logic [FLIT_W-1:0] flit_out_q;
    logic              flit_out_valid_q;
    logic              flit_out_vc_q;
    logic [1:0]        credit_out_q;
    logic              overflow_err_q;

    // Selection lags one cycle, so emptiness is judged on current occupancy.
    assign w_rd_ok = bus.out_ready && !bus.selected_vc[1];
    assign w_rd_vc = bus.selected_vc[0];

    for (genvar v = 0; v < 2; v++) begin : g_vc
        logic [FLIT_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q;
        logic [PTR_W-1:0]  rd_ptr_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              full;

        assign full          = (cnt_q == CNT_W'(DEPTH));
        assign w_nonempty[v] = (cnt_q != '0);
        assign w_wr_req[v]   = bus.in_valid && (bus.in_vc == 1'(v));
        assign w_rd_en[v]    = w_rd_ok && (w_rd_vc == 1'(v)) && w_nonempty[v];
        // A full VC still accepts a write when the same edge frees a slot.
        assign w_wr_en[v]    = w_wr_req[v] && (!full || w_rd_en[v]);
        assign cnt_d         = cnt_q + CNT_W'(w_wr_en[v]) - CNT_W'(w_rd_en[v]);
        assign w_head[v]     = mem_q[rd_ptr_q];

        always_ff @(posedge clk) begin
            if (w_wr_en[v]) begin
                mem_q[wr_ptr_q] <= bus.in_flit;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (w_wr_en[v]) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (w_rd_en[v]) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_out_q       <= '0;
            flit_out_valid_q <= 1'b0;
            flit_out_vc_q    <= 1'b0;
            credit_out_q     <= 2'b00;
            overflow_err_q   <= 1'b0;
        end else begin
            flit_out_valid_q <= |w_rd_en;
            credit_out_q     <= w_rd_en;
            if (|w_rd_en) begin
                flit_out_q    <= w_head[w_rd_vc];
                flit_out_vc_q <= w_rd_vc;
            end
            if (|(w_wr_req & ~w_wr_en)) begin
                overflow_err_q <= 1'b1;
            end
        end
    end

    assign bus.vc0_valid      = w_nonempty[0];
    assign bus.vc1_valid      = w_nonempty[1];
    assign bus.flit_out       = flit_out_q;
    assign bus.flit_out_valid = flit_out_valid_q;
    assign bus.flit_out_vc    = flit_out_vc_q;
    assign bus.credit_out     = credit_out_q;
    assign bus.overflow_err   = overflow_err_q;

endmodule

`default_nettype wire
